// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a length-prefixed, big-endian
// byte stream. Two length bytes give the word count N; every following group
// of four bytes is packed MSB-first into one 32-bit word and written at byte
// address index*4. The core is held in stall for the whole load.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for load_start; core runs, no bytes accepted
// LEN_HI | accept high byte of the word count
// LEN_LO | accept low byte of the word count; flag oversize
// DATA   | accept word bytes, shifting MSB-first into the word register
// WRITE  | one-cycle memory write of the assembled word (if in range)
// DONE   | one-cycle done pulse, core still held
module imem_loader #(
  parameter int SIZE   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [31:0] SIZE_W = 32'(SIZE);

  state_t             state_q, state_d;
  logic [7:0]         len_hi_q, len_hi_d;
  logic [15:0]        len_q, len_d;
  logic [15:0]        idx_q, idx_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [23:0]        word_q, word_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               err_q, err_d;

  logic               accept;
  logic [15:0]        len_in;
  logic [15:0]        idx_inc;
  logic [ADDR_W-1:0]  idx_addr;

  // Byte address of the current word index: zero-extended index times four.
  if (ADDR_W > 18) begin : g_addr_wide
    assign idx_addr = {{(ADDR_W-18){1'b0}}, idx_q, 2'b00};
  end else begin : g_addr_narrow
    logic [17:0] addr18;
    assign addr18   = {idx_q, 2'b00};
    assign idx_addr = addr18[ADDR_W-1:0];
  end

  assign in_ready  = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DATA);
  assign accept    = in_valid && in_ready;
  assign len_in    = {len_hi_q, in_data};
  assign idx_inc   = idx_q + 16'd1;

  assign cpu_hold  = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;

  // Next-state and datapath update; the write strobe, address and data are
  // registered on the edge that accepts the fourth byte so they are valid
  // throughout the WRITE cycle.
  always_comb begin
    state_d     = state_q;
    len_hi_d    = len_hi_q;
    len_d       = len_q;
    idx_d       = idx_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (load_start) begin
          err_d      = 1'b0;
          idx_d      = 16'd0;
          byte_cnt_d = 2'd0;
          state_d    = LEN_HI;
        end
      end

      LEN_HI: begin
        if (accept) begin
          len_hi_d = in_data;
          state_d  = LEN_LO;
        end
      end

      LEN_LO: begin
        if (accept) begin
          len_d   = len_in;
          err_d   = ({16'd0, len_in} > SIZE_W);
          state_d = (len_in == 16'd0) ? DONE : DATA;
        end
      end

      DATA: begin
        if (accept) begin
          word_d     = {word_q[15:0], in_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Words past the memory depth are consumed but never written.
            mem_we_d    = ({16'd0, idx_q} < SIZE_W);
            mem_addr_d  = idx_addr;
            mem_wdata_d = {word_q, in_data};
            state_d     = WRITE;
          end
        end
      end

      WRITE: begin
        idx_d   = idx_inc;
        state_d = (idx_inc == len_q) ? DONE : DATA;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any load in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      len_hi_q    <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_hi_q    <= len_hi_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (SIZE=32, ADDR_W=32).
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        load_start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  imem_loader #(.SIZE(32), .ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write / done observer, sampled mid-cycle.
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          last_we_cyc = 0;
  int          bad_ready = 0;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      last_we_cyc = cyc;
      if (in_ready) bad_ready++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int cnt;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $error("FAIL ready_timeout observed=in_ready low expected=in_ready high within 50 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic start_load();
    @(negedge clk);
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    send_byte(w[31:24], gaps);
    send_byte(w[23:16], gaps);
    send_byte(w[15:8], gaps);
    send_byte(w[7:0], gaps);
  endtask

  int wbase;
  int dbase;
  int rbase;
  int mism;

  initial begin
    reset      = 1'b0;
    load_start = 1'b0;
    in_data    = 8'h00;
    in_valid   = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_in_ready",  32'(in_ready), 32'd0);
    check("rst_mem_we",    32'(mem_we),   32'd0);
    check("rst_mem_addr",  mem_addr,      32'd0);
    check("rst_mem_wdata", mem_wdata,     32'd0);
    check("rst_cpu_hold",  32'(cpu_hold), 32'd0);
    check("rst_done",      32'(done),     32'd0);
    check("rst_err",       32'(err),      32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Basic load with back-to-back bytes
    wbase = wr_addr.size(); dbase = done_cnt; rbase = bad_ready;
    start_load();
    check("basic_lenhi_ready", 32'(in_ready), 32'd1);
    check("basic_lenhi_hold",  32'(cpu_hold), 32'd1);
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_word(32'h8C010004, 0);
    send_word(32'h8C220005, 0);
    check("basic_last_we",    32'(mem_we),   32'd1);
    check("basic_last_ready", 32'(in_ready), 32'd0);
    check("basic_last_addr",  mem_addr,      32'd4);
    check("basic_last_data",  mem_wdata,     32'h8C220005);
    @(posedge clk); #1;
    check("basic_done",       32'(done),     32'd1);
    check("basic_done_hold",  32'(cpu_hold), 32'd1);
    check("basic_done_we",    32'(mem_we),   32'd0);
    @(posedge clk); #1;
    check("basic_idle_done",  32'(done),     32'd0);
    check("basic_idle_hold",  32'(cpu_hold), 32'd0);
    @(negedge clk);
    check("basic_nwr",   32'(wr_addr.size() - wbase), 32'd2);
    check("basic_addr0", wr_addr[wbase],     32'd0);
    check("basic_data0", wr_data[wbase],     32'h8C010004);
    check("basic_addr1", wr_addr[wbase + 1], 32'd4);
    check("basic_data1", wr_data[wbase + 1], 32'h8C220005);
    check("basic_ndone", 32'(done_cnt - dbase), 32'd1);
    check("basic_done_after_we", 32'(done_cyc - last_we_cyc), 32'd1);
    check("basic_err", 32'(err), 32'd0);
    check("basic_ready_in_write", 32'(bad_ready - rbase), 32'd0);

    // Same stream with random gaps
    wbase = wr_addr.size(); dbase = done_cnt; rbase = bad_ready;
    start_load();
    send_byte(8'h00, 1); send_byte(8'h02, 1);
    send_word(32'h8C010004, 1);
    send_word(32'h8C220005, 1);
    repeat (4) @(negedge clk);
    check("gap_nwr",   32'(wr_addr.size() - wbase), 32'd2);
    check("gap_addr0", wr_addr[wbase],     32'd0);
    check("gap_data0", wr_data[wbase],     32'h8C010004);
    check("gap_addr1", wr_addr[wbase + 1], 32'd4);
    check("gap_data1", wr_data[wbase + 1], 32'h8C220005);
    check("gap_ndone", 32'(done_cnt - dbase), 32'd1);
    check("gap_ready_in_write", 32'(bad_ready - rbase), 32'd0);
    check("gap_idle_hold", 32'(cpu_hold), 32'd0);

    // Spurious load_start during DATA
    wbase = wr_addr.size(); dbase = done_cnt;
    start_load();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h8C, 0); send_byte(8'h01, 0);
    start_load();
    check("spur_still_busy", 32'(cpu_hold), 32'd1);
    send_byte(8'h00, 0); send_byte(8'h04, 0);
    send_word(32'h8C220005, 0);
    repeat (4) @(negedge clk);
    check("spur_nwr",   32'(wr_addr.size() - wbase), 32'd2);
    check("spur_addr0", wr_addr[wbase],     32'd0);
    check("spur_data0", wr_data[wbase],     32'h8C010004);
    check("spur_addr1", wr_addr[wbase + 1], 32'd4);
    check("spur_data1", wr_data[wbase + 1], 32'h8C220005);
    check("spur_ndone", 32'(done_cnt - dbase), 32'd1);

    // Oversize: N=33 with memory depth 32
    wbase = wr_addr.size(); dbase = done_cnt;
    start_load();
    check("over_err_before_len", 32'(err), 32'd0);
    send_byte(8'h00, 0); send_byte(8'h21, 0);
    check("over_err_set", 32'(err), 32'd1);
    for (int k = 0; k < 33; k++) send_word(32'h1000_0000 + 32'(k), 0);
    check("over_last_we", 32'(mem_we), 32'd0);
    check("over_last_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("over_done", 32'(done), 32'd1);
    repeat (3) @(negedge clk);
    check("over_nwr", 32'(wr_addr.size() - wbase), 32'd32);
    mism = 0;
    for (int k = 0; k < 32; k++) begin
      if (wbase + k < wr_addr.size()) begin
        if (wr_addr[wbase + k] !== 32'(4 * k) || wr_data[wbase + k] !== 32'h1000_0000 + 32'(k)) mism++;
      end
    end
    check("over_word_mismatches", 32'(mism), 32'd0);
    check("over_ndone", 32'(done_cnt - dbase), 32'd1);
    check("over_err_sticky", 32'(err), 32'd1);

    // Zero length; load_start also clears the sticky err
    wbase = wr_addr.size(); dbase = done_cnt;
    start_load();
    check("zero_err_cleared", 32'(err), 32'd0);
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_done_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    check("zero_idle_done", 32'(done), 32'd0);
    check("zero_idle_hold", 32'(cpu_hold), 32'd0);
    check("zero_idle_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("zero_nwr", 32'(wr_addr.size() - wbase), 32'd0);
    check("zero_ndone", 32'(done_cnt - dbase), 32'd1);

    // Reset after two bytes of the second word
    wbase = wr_addr.size(); dbase = done_cnt;
    start_load();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_word(32'h8C010004, 0);
    send_byte(8'h8C, 0); send_byte(8'h22, 0);
    reset = 1'b0;
    #1;
    check("mid_rst_hold",  32'(cpu_hold), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    check("mid_rst_we",    32'(mem_we),   32'd0);
    check("mid_rst_addr",  mem_addr,      32'd0);
    check("mid_rst_data",  mem_wdata,     32'd0);
    check("mid_rst_done",  32'(done),     32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_rst_nwr", 32'(wr_addr.size() - wbase), 32'd1);
    check("mid_rst_ndone", 32'(done_cnt - dbase), 32'd0);

    wbase = wr_addr.size(); dbase = done_cnt;
    start_load();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_word(32'h8C010004, 0);
    send_word(32'h8C220005, 0);
    repeat (4) @(negedge clk);
    check("post_rst_nwr",   32'(wr_addr.size() - wbase), 32'd2);
    check("post_rst_addr0", wr_addr[wbase],     32'd0);
    check("post_rst_data0", wr_data[wbase],     32'h8C010004);
    check("post_rst_addr1", wr_addr[wbase + 1], 32'd4);
    check("post_rst_data1", wr_data[wbase + 1], 32'h8C220005);
    check("post_rst_ndone", 32'(done_cnt - dbase), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the instruction memory from a byte stream before execution. It accepts a length-prefixed, big-endian byte stream over a valid/ready handshake and packs each group of four bytes into one 32-bit instruction word. It issues one write per word on the instruction-memory write port and holds the CPU in stall while loading. It is the writer for the instruction memory, which the core then reads by byte address (word index = address >> 2).

## Interface
Parameters:
- SIZE, 32, instruction-memory depth in words.
- ADDR_W, 32, width of the byte address driven to memory.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- load_start  input  1  single-cycle request to begin a load; sampled only in IDLE.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader can accept a byte; a byte transfers when in_valid && in_ready.
- mem_we  output  1  write strobe to instruction memory, one cycle per word.
- mem_addr  output  ADDR_W  byte address of the word being written; always a multiple of 4.
- mem_wdata  output  32  assembled instruction word.
- cpu_hold  output  1  stalls the core/PC while a load is active.
- done  output  1  one-cycle pulse at end of load.
- err  output  1  sticky flag: declared length exceeded SIZE; cleared by the next load_start or by reset.

## Operation
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE.
- IDLE: in_ready=0, cpu_hold=0. A load_start pulse clears err, clears the word index and byte counter, and moves to LEN_HI.
- LEN_HI / LEN_LO: in_ready=1. Two accepted bytes form the 16-bit word count N (high byte first).
  - After LEN_LO: N==0 goes to DONE; otherwise goes to DATA.
  - If N > SIZE, err is set in the cycle after LEN_LO is accepted.
- DATA: in_ready=1. Each accepted byte shifts into the word register MSB-first, so the first byte lands in bits [31:24]. After the 4th byte the FSM moves to WRITE.
- WRITE: in_ready=0; lasts one cycle.
  - mem_we=1 only if word index < SIZE; words beyond SIZE are consumed but never written.
  - mem_addr = word index × 4; mem_wdata = assembled word.
  - Word index then increments. If the index now equals N, go to DONE; otherwise return to DATA.
- DONE: done=1 for one cycle, then return to IDLE. cpu_hold is still 1 in DONE and drops in IDLE.
- cpu_hold=1 in every state except IDLE.
- load_start outside IDLE is ignored.
- Bytes presented while in_ready=0 are not consumed; the source must hold them.
- The word index is 16 bits. The address is the zero-extended index shifted left by 2. No wrap is possible because N ≤ 65535.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, err=0, counters=0.
- Reset mid-load aborts immediately. The partial word is discarded and no write is issued.
- load_start is accepted at edge t. The loader is in LEN_HI at t+1, so in_ready and cpu_hold are high from t+1.
- The 4th byte of a word is accepted at edge t. mem_we is high during cycle t+1, and in_ready is low in that same cycle.
- Peak throughput is 4 bytes per 5 cycles.
- The last write occurs in cycle w. done is high in cycle w+1, and cpu_hold is low from w+2.
- For N==0, done is high the cycle after LEN_LO is accepted.
- mem_addr and mem_wdata are registered and hold their last values outside WRITE.

## Test plan
- Basic load: load_start, then stream 00 02 8C 01 00 04 8C 22 00 05 with in_valid held high.
  - Required: write addr 0 data 0x8C010004, then write addr 4 data 0x8C220005, then done one cycle later.
  - cpu_hold is high from LEN_HI through DONE; err=0.
- Backpressure and gaps: same stream with in_valid toggled randomly (about 50%).
  - Required: identical writes and data; no byte is lost or duplicated.
  - in_ready is low in every WRITE cycle.
- Zero length: stream 00 00.
  - Required: no mem_we; done pulses the cycle after the second byte; back to IDLE.
- Oversize with SIZE=32: N=33 (00 21), then 132 bytes where word k = 0x1000_0000+k.
  - Required: err set after the length bytes; 32 writes at addr 0..124; word 32 consumed without a write; done pulses; err stays 1 until the next load_start.
- Reset mid-word: assert reset after 2 data bytes of word 1 in the basic stream.
  - Required: outputs take reset values at once and no write occurs for word 1.
  - A fresh load after release works normally.
- Spurious start: pulse load_start during DATA.
  - Required: it is ignored; the index and data sequence are unaffected.
